// File: rtl/z16_pkg.sv
// Shared types and constants for the Z16 writable instruction memory.
package z16_pkg;

  localparam int unsigned Z16_INSTR_W = 16;
  localparam logic [Z16_INSTR_W-1:0] Z16_NOP = 16'h0000;

  typedef enum logic [1:0] {
    CLEAR,
    IDLE,
    LD_LO,
    LD_HI
  } z16_state_e;

endpackage

// File: rtl/z16_mem_array.sv
// Single-port DEPTH x 16 synchronous RAM with a registered read port.
module z16_mem_array
  import z16_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_we,
  input  logic                   i_re,
  input  logic [AW-1:0]          i_addr,
  input  logic [Z16_INSTR_W-1:0] i_wdata,
  output logic [Z16_INSTR_W-1:0] o_rdata
);

  logic [Z16_INSTR_W-1:0] r_mem [DEPTH];
  logic [Z16_INSTR_W-1:0] r_rdata;

  // Array write; no reset so the storage maps onto a RAM macro.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  // Read register only updates on a read, so the last fetched word is held.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/z16_prog_memory.sv
// Writable Z16 instruction memory: clear sweep after reset, byte-stream
// program loader, and one-cycle registered halfword fetch.
module z16_prog_memory
  import z16_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_fetch_req,
  input  logic [ADDR_W-1:0]      i_addr,
  output logic [Z16_INSTR_W-1:0] o_instr,
  output logic                   o_instr_valid,
  output logic                   o_misalign,
  output logic                   o_oob,
  output logic                   o_busy,
  input  logic                   i_ld_start,
  input  logic                   i_ld_valid,
  input  logic [7:0]             i_ld_data,
  output logic                   o_ld_ready,
  input  logic                   i_ld_done,
  output logic [$clog2(DEPTH):0] o_ld_count,
  output logic                   o_ld_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  z16_state_e             r_state;
  logic [AW-1:0]          r_clr_ptr;
  logic [AW-1:0]          r_ld_ptr;
  logic [7:0]             r_lo;
  logic [CW-1:0]          r_ld_count;
  logic                   r_ld_overflow;
  logic                   r_busy;
  logic                   r_ld_ready;
  logic                   r_instr_valid;
  logic                   r_misalign;
  logic                   r_oob;

  logic [ADDR_W-2:0]      w_index;
  logic                   w_oob;
  logic                   w_fetch;
  logic                   w_ld_write;
  logic                   w_we;
  logic                   w_re;
  logic [AW-1:0]          w_mem_addr;
  logic [Z16_INSTR_W-1:0] w_wdata;
  logic [Z16_INSTR_W-1:0] w_rdata;

  assign w_index    = i_addr[ADDR_W-1:1];
  assign w_oob      = {1'b0, w_index} >= ADDR_W'(DEPTH);
  assign w_fetch    = (r_state == IDLE) && i_fetch_req && !i_ld_start && !i_rst;
  // Any LD_HI exit via byte or done commits a word (done alone pads hi with 0).
  assign w_ld_write = (r_state == LD_HI) && (i_ld_valid || i_ld_done) && !i_rst;

  // Single RAM port shared by the clear sweep, the loader and fetches.
  always_comb begin
    w_we       = 1'b0;
    w_re       = 1'b0;
    w_mem_addr = w_index[AW-1:0];
    w_wdata    = Z16_NOP;
    case (r_state)
      CLEAR: begin
        w_we       = !i_rst;
        w_mem_addr = r_clr_ptr;
      end
      LD_HI: begin
        w_we       = w_ld_write;
        w_mem_addr = r_ld_ptr;
        w_wdata    = {(i_ld_valid ? i_ld_data : 8'h00), r_lo};
      end
      IDLE: begin
        w_re = w_fetch && !w_oob;
      end
      default: ;
    endcase
  end

  z16_mem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_we    (w_we),
    .i_re    (w_re),
    .i_addr  (w_mem_addr),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata)
  );

  // Control FSM with registered status outputs and fetch flags.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= CLEAR;
      r_clr_ptr     <= '0;
      r_ld_ptr      <= '0;
      r_lo          <= '0;
      r_ld_count    <= '0;
      r_ld_overflow <= 1'b0;
      r_busy        <= 1'b1;
      r_ld_ready    <= 1'b0;
      r_instr_valid <= 1'b0;
      r_misalign    <= 1'b0;
      r_oob         <= 1'b0;
    end else begin
      r_instr_valid <= w_fetch;
      if (w_fetch) begin
        r_misalign <= i_addr[0];
        r_oob      <= w_oob;
      end
      if (w_ld_write) begin
        r_ld_ptr <= r_ld_ptr + AW'(1);
        if (r_ld_count != CW'(DEPTH)) begin
          r_ld_count <= r_ld_count + CW'(1);
        end
        if (r_ld_ptr == AW'(DEPTH - 1)) begin
          r_ld_overflow <= 1'b1;
        end
      end
      case (r_state)
        CLEAR: begin
          r_clr_ptr <= r_clr_ptr + AW'(1);
          if (r_clr_ptr == AW'(DEPTH - 1)) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        IDLE: begin
          if (i_ld_start) begin
            r_state       <= LD_LO;
            r_busy        <= 1'b1;
            r_ld_ready    <= 1'b1;
            r_ld_ptr      <= '0;
            r_ld_count    <= '0;
            r_ld_overflow <= 1'b0;
          end
        end
        LD_LO: begin
          if (i_ld_done) begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_ld_ready <= 1'b0;
          end else if (i_ld_valid) begin
            r_lo    <= i_ld_data;
            r_state <= LD_HI;
          end
        end
        LD_HI: begin
          if (i_ld_done) begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_ld_ready <= 1'b0;
          end else if (i_ld_valid) begin
            r_state <= LD_LO;
          end
        end
        default: begin
          r_state <= CLEAR;
        end
      endcase
    end
  end

  assign o_instr       = r_oob ? '0 : w_rdata;
  assign o_instr_valid = r_instr_valid;
  assign o_misalign    = r_misalign;
  assign o_oob         = r_oob;
  assign o_busy        = r_busy;
  assign o_ld_ready    = r_ld_ready;
  assign o_ld_count    = r_ld_count;
  assign o_ld_overflow = r_ld_overflow;

endmodule

// File: tb/tb_z16_prog_memory.sv
// Bench for z16_prog_memory: a DEPTH=256 and a DEPTH=4 instance against a
// word-level model of the program store.
module tb_z16_prog_memory;

  localparam int D0 = 256;
  localparam int D1 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  fetch_req, ld_start, ld_valid, ld_done;
  logic [15:0] addr    [2];
  logic [7:0]  ld_data [2];
  logic [15:0] instr   [2];
  logic [1:0]  valid, mis, oob, busy, ready, ovf;
  logic [8:0]  cnt0;
  logic [2:0]  cnt1;

  z16_prog_memory #(.DEPTH(D0), .ADDR_W(16)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_fetch_req(fetch_req[0]), .i_addr(addr[0]),
    .o_instr(instr[0]), .o_instr_valid(valid[0]), .o_misalign(mis[0]),
    .o_oob(oob[0]), .o_busy(busy[0]), .i_ld_start(ld_start[0]),
    .i_ld_valid(ld_valid[0]), .i_ld_data(ld_data[0]), .o_ld_ready(ready[0]),
    .i_ld_done(ld_done[0]), .o_ld_count(cnt0), .o_ld_overflow(ovf[0]));

  z16_prog_memory #(.DEPTH(D1), .ADDR_W(16)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_fetch_req(fetch_req[1]), .i_addr(addr[1]),
    .o_instr(instr[1]), .o_instr_valid(valid[1]), .o_misalign(mis[1]),
    .o_oob(oob[1]), .o_busy(busy[1]), .i_ld_start(ld_start[1]),
    .i_ld_valid(ld_valid[1]), .i_ld_data(ld_data[1]), .o_ld_ready(ready[1]),
    .i_ld_done(ld_done[1]), .o_ld_count(cnt1), .o_ld_overflow(ovf[1]));

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned n_fail   = 0;
  int unsigned depth [2] = '{D0, D1};
  logic [15:0] mm [2][256];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] get_cnt(input int d);
    return (d == 0) ? 32'(cnt0) : 32'(cnt1);
  endfunction

  task automatic model_clear();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 256; i++) mm[d][i] = 16'h0000;
  endtask

  function automatic logic [15:0] exp_instr(input int d, input logic [15:0] a);
    int unsigned idx = 32'(a) >> 1;
    return (idx >= depth[d]) ? 16'h0000 : mm[d][idx];
  endfunction

  task automatic check_fetch_out(input int d, input logic [15:0] a);
    int unsigned idx = 32'(a) >> 1;
    check("fetch_valid", 32'(valid[d]), 32'd1);
    check("fetch_instr", 32'(instr[d]), 32'(exp_instr(d, a)));
    check("fetch_misalign", 32'(mis[d]), 32'(a[0]));
    check("fetch_oob", 32'(oob[d]), (idx >= depth[d]) ? 32'd1 : 32'd0);
  endtask

  task automatic fetch(input int d, input logic [15:0] a);
    fetch_req[d] = 1'b1;
    addr[d]      = a;
    tick();
    fetch_req[d] = 1'b0;
    check_fetch_out(d, a);
  endtask

  // Byte i of the stream is b[8*i +: 8]; with_done presents the last byte together with i_ld_done.
  task automatic load(input int d, input logic [511:0] b, input int n, input bit with_done);
    int eff;
    int words;
    int exp_cnt;
    logic [7:0] lo, hi;
    ld_start[d] = 1'b1;
    tick();
    ld_start[d] = 1'b0;
    check("ld_ready_on", 32'(ready[d]), 32'd1);
    check("ld_busy_on", 32'(busy[d]), 32'd1);
    check("ld_count_clr", get_cnt(d), 32'd0);
    for (int i = 0; i < n; i++) begin
      ld_valid[d] = 1'b1;
      ld_data[d]  = b[8*i +: 8];
      if (with_done && i == n - 1) ld_done[d] = 1'b1;
      tick();
    end
    ld_valid[d] = 1'b0;
    if (!with_done || n == 0) begin
      ld_done[d] = 1'b1;
      tick();
    end
    ld_done[d] = 1'b0;
    check("ld_busy_off", 32'(busy[d]), 32'd0);
    check("ld_ready_off", 32'(ready[d]), 32'd0);
    // A byte arriving with done while a low byte is expected is dropped.
    eff = (with_done && n > 0 && (n % 2) == 1) ? n - 1 : n;
    words = (eff + 1) / 2;
    for (int w = 0; w < words; w++) begin
      lo = b[16*w +: 8];
      hi = (2*w + 1 < eff) ? b[16*w + 8 +: 8] : 8'h00;
      mm[d][w % depth[d]] = {hi, lo};
    end
    exp_cnt = (words > int'(depth[d])) ? int'(depth[d]) : words;
    check("ld_count", get_cnt(d), 32'(exp_cnt));
    check("ld_overflow", 32'(ovf[d]), (words >= int'(depth[d])) ? 32'd1 : 32'd0);
  endtask

  task automatic wait_clear();
    int t0 = -1;
    int t1 = -1;
    for (int k = 1; k <= 1000 && (t0 < 0 || t1 < 0); k++) begin
      tick();
      if (t0 < 0 && busy[0] == 1'b0) t0 = k;
      if (t1 < 0 && busy[1] == 1'b0) t1 = k;
    end
    check("clear_len_d256", 32'(t0), 32'(D0));
    check("clear_len_d4", 32'(t1), 32'(D1));
  endtask

  task automatic check_reset_state();
    for (int d = 0; d < 2; d++) begin
      check("rst_instr", 32'(instr[d]), 32'd0);
      check("rst_valid", 32'(valid[d]), 32'd0);
      check("rst_misalign", 32'(mis[d]), 32'd0);
      check("rst_oob", 32'(oob[d]), 32'd0);
      check("rst_busy", 32'(busy[d]), 32'd1);
      check("rst_ready", 32'(ready[d]), 32'd0);
      check("rst_count", get_cnt(d), 32'd0);
      check("rst_overflow", 32'(ovf[d]), 32'd0);
    end
  endtask

  logic [511:0] bytes;
  logic [15:0]  ra;
  int           n;
  bit           wd;

  initial begin
    rst = 1'b1;
    fetch_req = '0; ld_start = '0; ld_valid = '0; ld_done = '0;
    for (int d = 0; d < 2; d++) begin
      addr[d]    = '0;
      ld_data[d] = '0;
    end
    model_clear();

    // Reset and clear sweep
    tick();
    rst = 1'b0;
    check_reset_state();
    wait_clear();
    fetch(0, 16'h0010);
    check("nop_after_clear", 32'(instr[0]), 32'h0000);

    // Four-byte load, little-endian
    load(0, 512'h405A004B, 4, 1'b0);
    check("tp_count_2", get_cnt(0), 32'd2);
    fetch(0, 16'h0000);
    check("tp_word0", 32'(instr[0]), 32'h004B);
    fetch(0, 16'h0002);
    check("tp_word1", 32'(instr[0]), 32'h405A);
    tick();
    check("valid_drops", 32'(valid[0]), 32'd0);
    check("instr_holds", 32'(instr[0]), 32'h405A);

    // Odd load: done in LD_HI writes a partial word
    load(0, 512'hCCBBAA, 3, 1'b0);
    fetch(0, 16'h0002);
    check("partial_word", 32'(instr[0]), 32'h00CC);

    // Faults
    fetch(0, 16'h0201);
    check("oob_instr_zero", 32'(instr[0]), 32'h0000);
    check("oob_flag", 32'(oob[0]), 32'd1);
    fetch(0, 16'h0003);
    check("misalign_reads_word1", 32'(instr[0]), 32'h00CC);

    // Load start wins over fetch; fetches ignored while loading
    fetch_req[0] = 1'b1; ld_start[0] = 1'b1; addr[0] = 16'h0000;
    tick();
    ld_start[0] = 1'b0;
    check("start_priority_valid", 32'(valid[0]), 32'd0);
    check("start_priority_ready", 32'(ready[0]), 32'd1);
    tick();
    check("fetch_in_load_ignored", 32'(valid[0]), 32'd0);
    fetch_req[0] = 1'b0; ld_done[0] = 1'b1;
    tick();
    ld_done[0] = 1'b0;
    check("empty_load_count", get_cnt(0), 32'd0);
    check("empty_load_busy", 32'(busy[0]), 32'd0);

    // Done concurrent with a byte, in LD_LO (dropped) and in LD_HI (full word)
    load(0, 512'h332211, 3, 1'b1);
    load(0, 512'h44332211, 4, 1'b1);
    fetch(0, 16'h0002);
    check("done_with_byte_hi", 32'(instr[0]), 32'h4433);

    // Randomized loads and back-to-back fetch bursts
    for (int r = 0; r < 6; r++) begin
      n  = int'($urandom_range(1, 40));
      wd = 1'($urandom_range(0, 1));
      for (int i = 0; i < 64; i++) bytes[8*i +: 8] = 8'($urandom);
      load(0, bytes, n, wd);
      fetch_req[0] = 1'b1;
      for (int k = 0; k < 12; k++) begin
        ra = 16'($urandom_range(0, 4 * D0 - 1));
        if (k < 4) ra = 16'($urandom_range(0, 2 * 22 - 1));
        addr[0] = ra;
        tick();
        check_fetch_out(0, ra);
      end
      fetch_req[0] = 1'b0;
    end

    // Reset during a load restarts the clear sweep
    ld_start[0] = 1'b1;
    tick();
    ld_start[0] = 1'b0; ld_valid[0] = 1'b1; ld_data[0] = 8'h5C;
    tick();
    ld_valid[0] = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    model_clear();
    check_reset_state();
    wait_clear();
    for (int k = 0; k < 6; k++) begin
      ra = (k < 3) ? 16'(2 * k) : 16'($urandom_range(0, 2 * D0 - 1));
      fetch(0, ra);
      check("post_reset_nop", 32'(instr[0]), 32'h0000);
    end
    check("post_reset_count", get_cnt(0), 32'd0);

    // DEPTH=4 wrap: ten bytes are five words, the fifth lands in word 0
    load(1, 512'h0A090807060504030201, 10, 1'b0);
    check("wrap_overflow", 32'(ovf[1]), 32'd1);
    check("wrap_count_sat", get_cnt(1), 32'd4);
    fetch(1, 16'h0000);
    check("wrap_word5", 32'(instr[1]), 32'h0A09);
    for (int k = 1; k < 5; k++) fetch(1, 16'(2 * k));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
